// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a framed, checksummed image over a UART line and
// writes it word-by-word into one of N_BANKS target memories, then answers
// ACK (0x06) or NAK (0x15) on tx.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : single-cycle arm pulse
//   rx / tx    : UART receive (async, idle high) / transmit (idle high)
//   upg_wen    : one-cycle write strobe with upg_bank / upg_adr / upg_dat
//   upg_busy   : frame reception in progress
//   upg_done   : frame accepted (held until next start)
//   upg_err    : frame rejected (held until next start)
module uart_prog_loader #(
  parameter int unsigned CLK_HZ      = 10_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  localparam int unsigned BANK_W     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx,
  output logic              tx,
  output logic              upg_wen,
  output logic [BANK_W-1:0] upg_bank,
  output logic [ADDR_W-1:0] upg_adr,
  output logic [DATA_W-1:0] upg_dat,
  output logic              upg_busy,
  output logic              upg_done,
  output logic              upg_err
);

  localparam int unsigned DIV     = CLK_HZ / BAUD;
  localparam int unsigned HALF    = DIV / 2;
  localparam int unsigned CNT_W   = $clog2(DIV);
  localparam int unsigned BPW     = DATA_W / 8;
  localparam int unsigned BYTE_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned WCNT_W  = ADDR_W + 1;
  localparam int unsigned MAX_LEN = 1 << ADDR_W;
  localparam logic [7:0]  SYNC_B  = 8'hA5;
  localparam logic [7:0]  ACK_B   = 8'h06;
  localparam logic [7:0]  NAK_B   = 8'h15;

  // Two-flop synchroniser for the asynchronous rx line
  logic rx_m, rx_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // 8N1 receiver: start checked at half a bit, data/stop sampled every DIV
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_end_c, rx_valid_c, rx_ferr_c;

  assign rx_end_c   = (rx_state == R_STOP) && (rx_cnt == CNT_W'(DIV - 1));
  assign rx_valid_c = rx_end_c && rx_s;
  assign rx_ferr_c  = rx_end_c && !rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      unique case (rx_state)
        R_IDLE: if (!rx_s) begin
          rx_state <= R_START;
          rx_cnt   <= '0;
        end
        R_START: if (rx_cnt == CNT_W'(HALF - 1)) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s ? R_IDLE : R_DATA;   // high at mid-start: glitch
        end else rx_cnt <= rx_cnt + 1'b1;
        R_DATA: if (rx_cnt == CNT_W'(DIV - 1)) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state <= R_STOP;
          else                rx_bit   <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_STOP: if (rx_end_c) begin
          rx_cnt   <= '0;
          rx_state <= R_IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Frame protocol FSM, write port and ACK/NAK transmitter
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_BANK, S_LENL, S_LENH, S_DATA, S_CSUM, S_TX, S_DONE, S_ERR
  } state_t;
  state_t            state;
  logic [BANK_W-1:0] bank_q;
  logic [7:0]        len_lo;
  logic [15:0]       len_q;
  logic [WCNT_W-1:0] word_idx;
  logic [BYTE_W-1:0] byte_idx;
  logic [DATA_W-1:0] word_sh;
  logic [7:0]        sum;
  logic [TO_W-1:0]   to_cnt;
  logic              ack_q;
  logic [9:0]        tx_sh;
  logic [CNT_W-1:0]  tx_cnt;
  logic [3:0]        tx_bit;

  logic              frame_c, timeout_c, bad_bank_c, bad_len_c, nak_c;
  logic [15:0]       len_c;
  logic [DATA_W-1:0] word_next_c;

  assign frame_c     = (state == S_BANK) || (state == S_LENL) || (state == S_LENH) ||
                       (state == S_DATA) || (state == S_CSUM);
  assign timeout_c   = frame_c && !rx_valid_c && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign len_c       = {rx_sh, len_lo};
  assign bad_bank_c  = (state == S_BANK) && rx_valid_c && (32'(rx_sh) >= N_BANKS);
  assign bad_len_c   = (state == S_LENH) && rx_valid_c && (32'(len_c) > MAX_LEN);
  assign nak_c       = ((frame_c || state == S_SYNC) && rx_ferr_c) || timeout_c ||
                       bad_bank_c || bad_len_c;
  // little-endian assembly: new byte enters at the top of the word
  assign word_next_c = DATA_W'({rx_sh, word_sh} >> 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      upg_wen  <= 1'b0;
      upg_bank <= '0;
      upg_adr  <= '0;
      upg_dat  <= '0;
      upg_busy <= 1'b0;
      upg_done <= 1'b0;
      upg_err  <= 1'b0;
      bank_q   <= '0;
      len_lo   <= '0;
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_sh  <= '0;
      sum      <= '0;
      to_cnt   <= '0;
      ack_q    <= 1'b0;
      tx_sh    <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      upg_wen <= 1'b0;
      tx      <= 1'b1;
      if (rx_valid_c)                              to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT_CYC - 1))   to_cnt <= to_cnt + 1'b1;

      unique case (state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          state    <= S_SYNC;
          upg_done <= 1'b0;
          upg_err  <= 1'b0;
          upg_busy <= 1'b1;
        end
        S_SYNC: if (rx_valid_c && rx_sh == SYNC_B) state <= S_BANK;
        S_BANK: if (rx_valid_c) begin
          bank_q <= BANK_W'(rx_sh);
          sum    <= rx_sh;
          state  <= S_LENL;
        end
        S_LENL: if (rx_valid_c) begin
          len_lo <= rx_sh;
          sum    <= sum + rx_sh;
          state  <= S_LENH;
        end
        S_LENH: if (rx_valid_c) begin
          len_q    <= len_c;
          sum      <= sum + rx_sh;
          word_idx <= '0;
          byte_idx <= '0;
          state    <= (len_c == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (rx_valid_c) begin
          sum     <= sum + rx_sh;
          word_sh <= word_next_c;
          if (byte_idx == BYTE_W'(BPW - 1)) begin
            upg_wen  <= 1'b1;
            upg_dat  <= word_next_c;
            upg_adr  <= ADDR_W'(word_idx);
            upg_bank <= bank_q;
            byte_idx <= '0;
            word_idx <= word_idx + 1'b1;
            if (32'(word_idx) + 32'd1 == 32'(len_q)) state <= S_CSUM;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        S_CSUM: if (rx_valid_c) begin
          ack_q  <= (rx_sh == sum);
          tx_sh  <= {1'b1, (rx_sh == sum) ? ACK_B : NAK_B, 1'b0};
          tx_cnt <= '0;
          tx_bit <= '0;
          state  <= S_TX;
        end
        S_TX: begin
          tx <= tx_sh[0];
          if (tx_cnt == CNT_W'(DIV - 1)) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b1, tx_sh[9:1]};
            if (tx_bit == 4'd9) begin
              state    <= ack_q ? S_DONE : S_ERR;
              upg_done <= ack_q;
              upg_err  <= !ack_q;
              upg_busy <= 1'b0;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Any protocol error abandons the frame and answers NAK
      if (nak_c) begin
        ack_q  <= 1'b0;
        tx_sh  <= {1'b1, NAK_B, 1'b0};
        tx_cnt <= '0;
        tx_bit <= '0;
        state  <= S_TX;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed frames plus randomized frames checked
// against a byte-list reference model of the frame protocol.
module tb_uart_prog_loader;

  localparam int unsigned DIV     = 16;
  localparam int unsigned N_BANKS = 2;
  localparam int unsigned MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        rst, start, rx;
  logic        tx, upg_wen, upg_busy, upg_done, upg_err;
  logic [0:0]  upg_bank;
  logic [3:0]  upg_adr;
  logic [31:0] upg_dat;

  uart_prog_loader #(
    .CLK_HZ(160), .BAUD(10), .DATA_W(32), .ADDR_W(4), .N_BANKS(2), .TIMEOUT_CYC(400)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx(rx), .tx(tx),
    .upg_wen(upg_wen), .upg_bank(upg_bank), .upg_adr(upg_adr), .upg_dat(upg_dat),
    .upg_busy(upg_busy), .upg_done(upg_done), .upg_err(upg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed writes {bank, adr, dat} and tx bytes {stop, data}
  logic [47:0] got_wr[$];
  logic [8:0]  tx_q[$];
  logic [47:0] exp_wr[$];

  always @(negedge clk)
    if (upg_wen === 1'b1) got_wr.push_back({8'(upg_bank), 8'(upg_adr), upg_dat});

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (DIV / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        tx_q.push_back({tx, b});
      end
    end
  end

  // Reference model: walks the byte list by the frame rules, fills exp_wr,
  // returns the expected reply byte (running out of bytes means timeout)
  function automatic logic [7:0] model_frame(input logic [7:0] fr[$]);
    int p = 0;
    int bank, len;
    logic [7:0]  sum;
    logic [31:0] word;
    exp_wr.delete();
    while (p < fr.size() && fr[p] != 8'hA5) p++;
    p++;
    if (p >= fr.size()) return 8'h15;
    bank = int'(fr[p]); sum = fr[p]; p++;
    if (bank >= N_BANKS) return 8'h15;
    if (p >= fr.size()) return 8'h15;
    len = int'(fr[p]); sum += fr[p]; p++;
    if (p >= fr.size()) return 8'h15;
    len += 256 * int'(fr[p]); sum += fr[p]; p++;
    if (len > MAX_LEN) return 8'h15;
    for (int w = 0; w < len; w++) begin
      word = 0;
      for (int k = 0; k < 4; k++) begin
        if (p >= fr.size()) return 8'h15;
        word = word | (32'(fr[p]) << (8 * k));
        sum += fr[p]; p++;
      end
      exp_wr.push_back({8'(bank), 8'(w), word});
    end
    if (p >= fr.size()) return 8'h15;
    return (fr[p] == sum) ? 8'h06 : 8'h15;
  endfunction

  function automatic logic [7:0] csum_of(input logic [7:0] fr[$]);
    logic [7:0] s = 0;
    int p = 0;
    while (fr[p] != 8'hA5) p++;
    for (int i = p + 1; i < fr.size(); i++) s += fr[i];
    return s;
  endfunction

  task automatic uart_send(input logic [7:0] b);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [7:0] fr[$], input int glitch_at);
    logic [7:0] exp_resp;
    int n;
    exp_resp = model_frame(fr);
    got_wr.delete();
    tx_q.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({name, " busy_after_start"}, 64'(upg_busy), 64'd1);
    check({name, " done_err_clear"}, 64'({upg_done, upg_err}), 64'd0);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == glitch_at) begin
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
      end
      uart_send(fr[i]);
    end
    n = 0;
    while (tx_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * DIV) @(negedge clk);
    check({name, " reply_count"}, 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) check({name, " reply"}, 64'(tx_q[0]), 64'({1'b1, exp_resp}));
    check({name, " write_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check($sformatf("%s write%0d", name, i), 64'(got_wr[i]), 64'(exp_wr[i]));
    check({name, " done"}, 64'(upg_done), 64'(exp_resp == 8'h06));
    check({name, " err"}, 64'(upg_err), 64'(exp_resp == 8'h15));
    check({name, " busy_end"}, 64'(upg_busy), 64'd0);
  endtask

  initial begin : main
    logic [7:0] fr[$];
    int nj, len;
    rst = 1'b1; start = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", 64'(tx), 64'd1);
    check("reset outs", 64'({upg_wen, upg_busy, upg_done, upg_err}), 64'd0);
    check("reset bus", 64'({upg_bank, upg_adr, upg_dat}), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    fr = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE};
    fr.push_back(csum_of(fr));
    run_frame("two_words", fr, -1);

    fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("junk_len0", fr, -1);

    fr = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run_frame("bad_csum", fr, -1);

    fr = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0A};
    run_frame("bad_bank", fr, -1);

    fr = '{8'hA5, 8'h00};
    run_frame("timeout", fr, -1);

    fr = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
    run_frame("glitch", fr, 2);

    fr = '{8'hA5, 8'h01, 8'h11, 8'h00};
    run_frame("len17", fr, -1);

    fr = '{8'hA5, 8'h01, 8'h10, 8'h00};
    for (int i = 0; i < 64; i++) fr.push_back(8'($urandom));
    fr.push_back(csum_of(fr));
    run_frame("len16", fr, -1);

    // Reset in the middle of the data phase
    got_wr.delete();
    tx_q.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    fr = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    foreach (fr[i]) uart_send(fr[i]);
    check("pre_rst writes", 64'(got_wr.size()), 64'd1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst tx", 64'(tx), 64'd1);
    check("midrst outs", 64'({upg_wen, upg_busy, upg_done, upg_err}), 64'd0);
    check("midrst bus", 64'({upg_bank, upg_adr, upg_dat}), 64'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    got_wr.delete();
    repeat (600) @(negedge clk);
    check("post_rst writes", 64'(got_wr.size()), 64'd0);
    check("post_rst tx", 64'(tx_q.size()), 64'd0);
    check("post_rst busy", 64'(upg_busy), 64'd0);

    // Randomized frames: junk prefix, bad bank/len, corrupted csum, truncation
    for (int t = 0; t < 8; t++) begin
      fr.delete();
      nj = $urandom_range(0, 2);
      for (int i = 0; i < nj; i++) begin
        fr.push_back(8'($urandom));
        if (fr[i] == 8'hA5) fr[i] = 8'h5A;
      end
      fr.push_back(8'hA5);
      fr.push_back(($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255))
                                               : 8'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin
        fr.push_back(8'($urandom_range(17, 40)));
        fr.push_back(8'h00);
      end else begin
        len = $urandom_range(0, 4);
        fr.push_back(8'(len));
        fr.push_back(8'h00);
        for (int i = 0; i < 4 * len; i++) fr.push_back(8'($urandom));
        fr.push_back(csum_of(fr) ^ (($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255))
                                                                : 8'h00));
        if ($urandom_range(0, 5) == 0)
          while (fr.size() > nj + 1 + $urandom_range(1, 3)) void'(fr.pop_back());
      end
      run_frame($sformatf("rand%0d", t), fr, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
